// File: rtl/uart_fifo_ctrl.sv
// MMIO-side UART controller: TX/RX byte FIFOs, DATA/STATUS/CTRL registers and a level irq.
// TX drains to the PHY over valid/ready; RX bytes are always accepted and dropped with overrun when full.
module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_req,
  input  logic        mmio_we,
  input  logic [3:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic        mmio_rvalid,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  phy_tx_data,
  output logic        phy_tx_valid,
  input  logic        phy_tx_ready,
  input  logic [7:0]  phy_rx_data,
  input  logic        phy_rx_valid,
  output logic        phy_rx_ready,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];

  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          ovr_q, ovr_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic [1:0]    sel;
  logic          wr, rd;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, rx_ovf;
  logic [31:0]   status;
  logic          unused_ok;

  assign sel       = mmio_addr[3:2];
  assign wr        = mmio_req & mmio_we;
  assign rd        = mmio_req & ~mmio_we;
  assign unused_ok = ^{mmio_addr[1:0], mmio_wdata[31:8]};

  // Full/empty come from pre-cycle state so a simultaneous push and pop both proceed.
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push = wr && (sel == REG_DATA) && !tx_full;
  assign tx_pop  = !tx_empty && phy_tx_ready;
  assign rx_push = phy_rx_valid && !rx_full;
  assign rx_ovf  = phy_rx_valid && rx_full;
  assign rx_pop  = rd && (sel == REG_DATA) && !rx_empty;

  assign status = {8'b0, 8'(tx_cnt_q), 8'(rx_cnt_q), 3'b0,
                   ovr_q, tx_full, tx_empty, rx_full, !rx_empty};

  assign phy_tx_data  = tx_mem_q[tx_rptr_q];
  assign phy_tx_valid = !tx_empty;
  assign phy_rx_ready = 1'b1;
  assign mmio_rvalid  = rvalid_q;
  assign mmio_rdata   = rdata_q;
  assign irq          = irq_q;

  // Storage carries no reset; the counts alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= mmio_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= phy_rx_data;
  end

  always_comb begin
    tx_wptr_d = tx_wptr_q + AW'(tx_push);
    tx_rptr_d = tx_rptr_q + AW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wptr_d = rx_wptr_q + AW'(rx_push);
    rx_rptr_d = rx_rptr_q + AW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    ctrl_d = ctrl_q;
    ovr_d  = ovr_q;
    if (wr && (sel == REG_CTRL)) begin
      ctrl_d = mmio_wdata[1:0];
      if (mmio_wdata[4]) ovr_d = 1'b0;
    end
    // A fresh overrun outranks a clear written in the same cycle.
    if (rx_ovf) ovr_d = 1'b1;

    rvalid_d = rd;
    rdata_d  = '0;
    if (rd) begin
      case (sel)
        REG_DATA:   rdata_d = rx_empty ? 32'h8000_0000 : {24'b0, rx_mem_q[rx_rptr_q]};
        REG_STATUS: rdata_d = status;
        REG_CTRL:   rdata_d = {30'b0, ctrl_q};
        default:    rdata_d = '0;
      endcase
    end

    irq_d = (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      ctrl_q    <= '0;
      ovr_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      ctrl_q    <= ctrl_d;
      ovr_q     <= ovr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: TX drain, TX full drop, RX read, overrun, irq and mid-run reset.
module tb_uart_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_req, mmio_we;
  logic [3:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_rvalid;
  logic [31:0] mmio_rdata;
  logic [7:0]  phy_tx_data;
  logic        phy_tx_valid, phy_tx_ready;
  logic [7:0]  phy_rx_data;
  logic        phy_rx_valid, phy_rx_ready;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd_v;

  uart_fifo_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rvalid(mmio_rvalid), .mmio_rdata(mmio_rdata),
    .phy_tx_data(phy_tx_data), .phy_tx_valid(phy_tx_valid), .phy_tx_ready(phy_tx_ready),
    .phy_rx_data(phy_rx_data), .phy_rx_valid(phy_rx_valid), .phy_rx_ready(phy_rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    mmio_req = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    @(negedge clk);
    mmio_req = 1'b0; mmio_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = a;
    @(negedge clk);
    mmio_req = 1'b0;
    check("rvalid", {31'b0, mmio_rvalid}, 32'd1);
    d = mmio_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    phy_rx_valid = 1'b1; phy_rx_data = b;
    @(negedge clk);
    phy_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mmio_req = 1'b0; mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    phy_tx_ready = 1'b0; phy_rx_valid = 1'b0; phy_rx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", {31'b0, phy_tx_valid}, 32'd0);
    check("rst_irq",      {31'b0, irq}, 32'd0);
    check("rst_rvalid",   {31'b0, mmio_rvalid}, 32'd0);
    check("rst_rdata",    mmio_rdata, 32'd0);
    check("rx_ready",     {31'b0, phy_rx_ready}, 32'd1);
    rst = 1'b0;
    bus_read(4'h4, rd_v); check("rst_status", rd_v, 32'h0000_0004);
    bus_read(4'h8, rd_v); check("rst_ctrl", rd_v, 32'h0);
    @(negedge clk);
    check("idle_rvalid", {31'b0, mmio_rvalid}, 32'd0);
    check("idle_rdata",  mmio_rdata, 32'd0);

    // 1: three bytes drained in order
    bus_write(4'h0, 32'h41); bus_write(4'h0, 32'h42); bus_write(4'h0, 32'h43);
    bus_read(4'h4, rd_v); check("t1_status3", rd_v, 32'h0003_0000);
    phy_tx_ready = 1'b1;
    check("t1_b0", {24'b0, phy_tx_data}, 32'h41);
    @(negedge clk); check("t1_b1", {24'b0, phy_tx_data}, 32'h42);
    @(negedge clk); check("t1_b2", {24'b0, phy_tx_data}, 32'h43);
    @(negedge clk); check("t1_valid0", {31'b0, phy_tx_valid}, 32'd0);
    phy_tx_ready = 1'b0;
    bus_read(4'h4, rd_v); check("t1_status0", rd_v, 32'h0000_0004);

    // 2: seventeenth write dropped when full
    for (int i = 0; i < 17; i++) bus_write(4'h0, 32'h10 + i);
    bus_read(4'h4, rd_v); check("t2_status_full", rd_v, 32'h0010_0008);
    bus_write(4'h4, 32'hFFFF_FFFF);
    bus_read(4'h4, rd_v); check("t2_status_ro", rd_v, 32'h0010_0008);
    phy_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", {24'b0, phy_tx_data}, 32'h10 + i);
      @(negedge clk);
    end
    check("t2_valid0", {31'b0, phy_tx_valid}, 32'd0);
    phy_tx_ready = 1'b0;

    // 3: single RX byte then empty read
    rx_byte(8'h55);
    bus_read(4'h4, rd_v); check("t3_status", rd_v, 32'h0000_0105);
    bus_read(4'h0, rd_v); check("t3_data", rd_v, 32'h0000_0055);
    bus_read(4'h0, rd_v); check("t3_empty", rd_v, 32'h8000_0000);
    bus_read(4'h4, rd_v); check("t3_status0", rd_v, 32'h0000_0004);
    bus_read(4'hC, rd_v); check("t3_reserved", rd_v, 32'h0);

    // 4: overrun on the seventeenth RX byte, then W1C
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      phy_rx_valid = 1'b1; phy_rx_data = 8'h60 + 8'(i);
    end
    @(negedge clk); phy_rx_valid = 1'b0;
    bus_read(4'h4, rd_v); check("t4_status_ovr", rd_v, 32'h0000_1017);
    bus_write(4'h8, 32'h10);
    bus_read(4'h4, rd_v); check("t4_status_clr", rd_v, 32'h0000_1007);
    bus_read(4'h8, rd_v); check("t4_ctrl", rd_v, 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h0, rd_v); check("t4_rx", rd_v, 32'h60 + i);
    end
    bus_read(4'h0, rd_v); check("t4_rx_empty", rd_v, 32'h8000_0000);

    // 5: interrupt enables
    bus_write(4'h8, 32'h1);
    @(negedge clk); check("t5_irq_idle", {31'b0, irq}, 32'd0);
    rx_byte(8'h77);
    @(negedge clk); check("t5_irq_rx", {31'b0, irq}, 32'd1);
    bus_read(4'h0, rd_v); check("t5_data", rd_v, 32'h77);
    @(negedge clk); check("t5_irq_clear", {31'b0, irq}, 32'd0);
    bus_write(4'h8, 32'h2);
    @(negedge clk); check("t5_irq_tx", {31'b0, irq}, 32'd1);
    bus_write(4'h8, 32'h0);
    @(negedge clk); check("t5_irq_off", {31'b0, irq}, 32'd0);

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'hB0 + i);
    for (int i = 0; i < 3; i++) rx_byte(8'hC0 + 8'(i));
    bus_write(4'h8, 32'h3);
    phy_tx_ready = 1'b1;
    @(negedge clk);
    check("t6_pre_valid", {31'b0, phy_tx_valid}, 32'd1);
    check("t6_pre_data", {24'b0, phy_tx_data}, 32'hB1);
    check("t6_pre_irq", {31'b0, irq}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, phy_tx_valid}, 32'd0);
    check("t6_rst_irq", {31'b0, irq}, 32'd0);
    phy_tx_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus_read(4'h4, rd_v); check("t6_status", rd_v, 32'h0000_0004);
    bus_write(4'h0, 32'hA1); bus_write(4'h0, 32'hA2);
    phy_tx_ready = 1'b1;
    check("t6_a1", {24'b0, phy_tx_data}, 32'hA1);
    @(negedge clk); check("t6_a2", {24'b0, phy_tx_data}, 32'hA2);
    @(negedge clk); check("t6_valid0", {31'b0, phy_tx_valid}, 32'd0);
    phy_tx_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
